// File: rtl/nios2_nios2_mul_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nios2_nios2_mul_sequencer_if : request/response and multiplier-cell bus
// Revision: 1.0
// ----------------------------------------------------------------------------
interface nios2_nios2_mul_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic [31:0] mul_src1;
   logic [31:0] mul_src2;
   logic [31:0] mul_cell_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;

   modport slave (
      input  req_valid, req_op, req_src1, req_src2, mul_cell_result, rsp_ready,
      output req_ready, mul_src1, mul_src2, rsp_valid, rsp_result
   );

   modport master (
      output req_valid, req_op, req_src1, req_src2, mul_cell_result, rsp_ready,
      input  req_ready, mul_src1, mul_src2, rsp_valid, rsp_result
   );
endinterface
`default_nettype wire

// File: rtl/nios2_nios2_mul_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nios2_nios2_mul_sequencer : 32x32 multiply built from four 16x16 cell passes
// Revision: 1.0
// ----------------------------------------------------------------------------
module nios2_nios2_mul_sequencer #(
   parameter int MUL_LATENCY = 1
) (
   input  wire logic                   clk,
   input  wire logic                   reset,
   nios2_nios2_mul_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_DRAIN   = 3'd2,
      S_CORRECT = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXSU = 2'b10;
   localparam logic [1:0] OP_MULXSS = 2'b11;

   state_t      state_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [1:0]  op_q;
   logic [1:0]  k_q;
   logic [2:0]  cap_cnt_q;
   logic [63:0] acc_q;
   logic [2:0]  tag_q [MUL_LATENCY];
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_result_q;
   logic [31:0] mul_src1_q;
   logic [31:0] mul_src2_q;

   logic [1:0]  k_nxt_d;
   logic [15:0] a_half_d;
   logic [15:0] b_half_d;
   logic [2:0]  tag_in_d;
   logic [2:0]  tag_out_d;
   logic [1:0]  shift_sel_d;
   logic [63:0] shifted_d;
   logic [63:0] acc_d;
   logic [31:0] corr_d;
   logic [31:0] hi_d;

   // Tag layout {valid, a_idx, b_idx}; k walks (0,0),(1,0),(0,1),(1,1).
   always_comb begin
      k_nxt_d     = k_q + 2'd1;
      a_half_d    = k_nxt_d[0] ? a_q[31:16] : a_q[15:0];
      b_half_d    = k_nxt_d[1] ? b_q[31:16] : b_q[15:0];
      tag_in_d    = (state_q == S_ISSUE) ? {1'b1, k_q[0], k_q[1]} : 3'b000;
      tag_out_d   = tag_q[MUL_LATENCY-1];
      shift_sel_d = {1'b0, tag_out_d[1]} + {1'b0, tag_out_d[0]};
      case (shift_sel_d)
         2'd0:    shifted_d = {32'h0, bus.mul_cell_result};
         2'd1:    shifted_d = {16'h0, bus.mul_cell_result, 16'h0};
         default: shifted_d = {bus.mul_cell_result, 32'h0};
      endcase
      acc_d = acc_q + shifted_d;
      case (op_q)
         OP_MULXSS: corr_d = (a_q[31] ? b_q : 32'h0) + (b_q[31] ? a_q : 32'h0);
         OP_MULXSU: corr_d = a_q[31] ? b_q : 32'h0;
         default:   corr_d = 32'h0;
      endcase
      hi_d = acc_q[63:32] - corr_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         a_q          <= 32'h0;
         b_q          <= 32'h0;
         op_q         <= 2'b00;
         k_q          <= 2'd0;
         cap_cnt_q    <= 3'd0;
         acc_q        <= 64'h0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 32'h0;
         mul_src1_q   <= 32'h0;
         mul_src2_q   <= 32'h0;
         for (int i = 0; i < MUL_LATENCY; i++) begin
            tag_q[i] <= 3'b000;
         end
      end else begin
         tag_q[0] <= tag_in_d;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         if (tag_out_d[2]) begin
            acc_q     <= acc_d;
            cap_cnt_q <= cap_cnt_q + 3'd1;
         end

         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  a_q         <= bus.req_src1;
                  b_q         <= bus.req_src2;
                  op_q        <= bus.req_op;
                  k_q         <= 2'd0;
                  acc_q       <= 64'h0;
                  cap_cnt_q   <= 3'd0;
                  mul_src1_q  <= {16'h0, bus.req_src1[15:0]};
                  mul_src2_q  <= {16'h0, bus.req_src2[15:0]};
                  req_ready_q <= 1'b0;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (k_q == 2'd3) begin
                  mul_src1_q <= 32'h0;
                  mul_src2_q <= 32'h0;
                  state_q    <= S_DRAIN;
               end else begin
                  k_q        <= k_nxt_d;
                  mul_src1_q <= {16'h0, a_half_d};
                  mul_src2_q <= {16'h0, b_half_d};
               end
            end
            S_DRAIN: begin
               if (tag_out_d[2] && (cap_cnt_q == 3'd3)) begin
                  state_q <= S_CORRECT;
               end
            end
            S_CORRECT: begin
               rsp_result_q <= (op_q == OP_MUL) ? acc_q[31:0] : hi_d;
               rsp_valid_q  <= 1'b1;
               state_q      <= S_DONE;
            end
            S_DONE: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.mul_src1   = mul_src1_q;
   assign bus.mul_src2   = mul_src2_q;
endmodule
`default_nettype wire
